// File: rtl/audio_mix_sched_if.sv
// Channel source bundle for the audio mixer: four unsigned samples with a
// per-channel valid/ready handshake. The source side is the master, the
// mixer/scheduler is the slave and returns the one-cycle ready pulses.
interface audio_mix_sched_if #(
  parameter int WIDTH = 6
);
  logic [4*(WIDTH-2)-1:0] ch_data;
  logic [3:0]             ch_valid;
  logic [3:0]             ch_ready;

  modport master (
    output ch_data,
    output ch_valid,
    input  ch_ready
  );

  modport slave (
    input  ch_data,
    input  ch_valid,
    output ch_ready
  );
endinterface

// File: rtl/audio_mix_sched.sv
// Sample scheduler and mixer feeding the PWM delta-modulator data port.
// A free-running prescaler defines the sample period; on each sample tick the
// enabled channels are handshaked and their samples captured, the sum is
// clipped to a ramped ceiling so that turning audio on or off never pops.
module audio_mix_sched #(
  parameter int WIDTH = 6,
  parameter int DIV   = 64,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [3:0]           ch_mask_i,
  audio_mix_sched_if.slave     ch_if,
  input  logic                 clr_underrun_i,
  output logic [WIDTH-1:0]     pwm_data_o,
  output logic                 sample_tick_o,
  output logic [3:0]           underrun_o,
  output logic                 active_o
);

  localparam int SW = WIDTH - 2;
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0]    CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   LEVEL_TOP = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] LEVEL_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [SW-1:0]    ZERO_S    = {SW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_RUN       = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [SW-1:0]    samp_q [4];
  logic [SW-1:0]    samp_d [4];
  logic [3:0]       under_q, under_d;
  logic [WIDTH-1:0] pwm_q, pwm_d;

  logic             tick_s;
  logic [3:0]       ready_s;
  logic [3:0]       set_s;
  logic [WIDTH:0]   lvl_up_raw_s;
  logic [WIDTH-1:0] lvl_up_s;
  logic [WIDTH-1:0] lvl_dn_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] mix_s;

  // The tick and the ready pulses are decoded straight from registered state
  // so the source sees them in the same cycle the capture edge closes.
  assign tick_s        = (cnt_q == CNT_LAST);
  assign ready_s       = (tick_s && (state_q != S_IDLE)) ? ch_mask_i : 4'b0000;
  assign ch_if.ch_ready = ready_s;
  assign sample_tick_o = tick_s;
  assign underrun_o    = under_q;
  assign active_o      = (state_q != S_IDLE);
  assign pwm_data_o    = pwm_q;

  // Saturating ceiling steps; one extra bit catches the overflow past full scale.
  assign lvl_up_raw_s = {1'b0, level_q} + STEP_W;
  assign lvl_up_s     = (lvl_up_raw_s > LEVEL_TOP) ? LEVEL_MAX : lvl_up_raw_s[WIDTH-1:0];
  assign lvl_dn_s     = ({1'b0, level_q} <= STEP_W) ? ZERO_W
                                                    : (level_q - STEP_W[WIDTH-1:0]);

  // Four samples of WIDTH-2 bits can never exceed WIDTH bits, so no clipping here.
  assign sum_s = WIDTH'(samp_q[0]) + WIDTH'(samp_q[1]) + WIDTH'(samp_q[2]) + WIDTH'(samp_q[3]);
  assign mix_s = (sum_s < level_q) ? sum_s : level_q;

  // Prescaler: wraps at DIV-1 in every state.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Ramp FSM: the level update always follows the rule of the state held in
  // this cycle, even when the state itself changes on the same edge.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_RAMP_UP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RAMP_UP: begin
        if (tick_s) begin
          level_d = lvl_up_s;
        end else begin
          level_d = level_q;
        end
        if (!enable_i) begin
          state_d = S_RAMP_DOWN;
        end else if (tick_s && (lvl_up_s == LEVEL_MAX)) begin
          state_d = S_RUN;
        end else begin
          state_d = S_RAMP_UP;
        end
      end
      S_RUN: begin
        if (!enable_i) begin
          state_d = S_RAMP_DOWN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RAMP_DOWN: begin
        if (tick_s) begin
          level_d = lvl_dn_s;
        end else begin
          level_d = level_q;
        end
        if (enable_i) begin
          state_d = S_RAMP_UP;
        end else if (tick_s && (lvl_dn_s == ZERO_W)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RAMP_DOWN;
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = ZERO_W;
      end
    endcase
  end

  // Sample capture and underrun detection; masked channels are zeroed on every
  // tick so a re-enabled channel starts silent rather than with stale data.
  always_comb begin
    set_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      samp_d[i] = samp_q[i];
      if (tick_s) begin
        if (!ch_mask_i[i]) begin
          samp_d[i] = ZERO_S;
        end else if (ready_s[i] && ch_if.ch_valid[i]) begin
          samp_d[i] = ch_if.ch_data[i*SW +: SW];
        end else if (ready_s[i]) begin
          set_s[i] = 1'b1;
        end else begin
          samp_d[i] = samp_q[i];
        end
      end else begin
        samp_d[i] = samp_q[i];
      end
    end
    if (clr_underrun_i) begin
      under_d = set_s;
    end else begin
      under_d = under_q | set_s;
    end
  end

  // Output mix: silent in IDLE, otherwise the sum clipped to the ramp ceiling.
  always_comb begin
    pwm_d = ZERO_W;
    if (state_q == S_IDLE) begin
      pwm_d = ZERO_W;
    end else begin
      pwm_d = mix_s;
    end
  end

  // State registers with synchronous reset straight to IDLE (no ramp-down).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      level_q <= ZERO_W;
      under_q <= 4'b0000;
      pwm_q   <= ZERO_W;
      for (int i = 0; i < 4; i++) begin
        samp_q[i] <= ZERO_S;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      under_q <= under_d;
      pwm_q   <= pwm_d;
      for (int i = 0; i < 4; i++) begin
        samp_q[i] <= samp_d[i];
      end
    end
  end

endmodule

// File: tb/tb_audio_mix_sched.sv
// Self-checking bench for audio_mix_sched (WIDTH=6, DIV=4, STEP=8).
// Directed scenarios followed by a randomized phase, all compared every cycle
// against a behavioural reference model kept in this file.
module tb_audio_mix_sched;

  localparam int WIDTH = 6;
  localparam int DIV   = 4;
  localparam int STEP  = 8;
  localparam int LMAX  = 63;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_RUN  = 2;
  localparam int M_DOWN = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [3:0]       mask;
  logic             clr;
  logic [WIDTH-1:0] pwm;
  logic             tick;
  logic [3:0]       under;
  logic             active;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // reference model state
  int         m_mode;
  int         m_cnt;
  int         m_level;
  int         m_samp [4];
  logic [3:0] m_under;
  int         m_pwm;

  audio_mix_sched_if #(.WIDTH(WIDTH)) ch_if ();

  audio_mix_sched #(
    .WIDTH(WIDTH),
    .DIV  (DIV),
    .STEP (STEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable),
    .ch_mask_i     (mask),
    .ch_if         (ch_if),
    .clr_underrun_i(clr),
    .pwm_data_o    (pwm),
    .sample_tick_o (tick),
    .underrun_o    (under),
    .active_o      (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_cnt   = 0;
    m_level = 0;
    m_under = 4'b0000;
    m_pwm   = 0;
    for (int i = 0; i < 4; i++) m_samp[i] = 0;
  endtask

  // One clock of the reference behaviour, using the inputs held this cycle.
  task automatic model_advance();
    bit         t;
    int         sum;
    int         nxt_pwm;
    logic [3:0] set_v;
    t   = (m_cnt == DIV - 1);
    sum = m_samp[0] + m_samp[1] + m_samp[2] + m_samp[3];
    nxt_pwm = (m_mode == M_IDLE) ? 0 : ((sum < m_level) ? sum : m_level);
    set_v = 4'b0000;
    if (t) begin
      for (int i = 0; i < 4; i++) begin
        if (!mask[i]) m_samp[i] = 0;
        else if (m_mode != M_IDLE) begin
          if (ch_if.ch_valid[i]) m_samp[i] = (int'(ch_if.ch_data) >> (4 * i)) & 15;
          else set_v[i] = 1'b1;
        end
      end
    end
    m_under = clr ? set_v : (m_under | set_v);
    case (m_mode)
      M_IDLE: if (enable) m_mode = M_UP;
      M_UP: begin
        if (t) m_level = (m_level + STEP > LMAX) ? LMAX : m_level + STEP;
        if (!enable) m_mode = M_DOWN;
        else if (t && m_level == LMAX) m_mode = M_RUN;
      end
      M_RUN: if (!enable) m_mode = M_DOWN;
      default: begin
        if (t) m_level = (m_level - STEP < 0) ? 0 : m_level - STEP;
        if (enable) m_mode = M_UP;
        else if (t && m_level == 0) m_mode = M_IDLE;
      end
    endcase
    m_cnt = (m_cnt + 1) % DIV;
    m_pwm = nxt_pwm;
  endtask

  // Compare this cycle's outputs mid-cycle, then advance model and clock.
  task automatic step();
    bit         t_e;
    logic [3:0] rdy_e;
    @(negedge clk);
    if (checking) begin
      t_e   = (m_cnt == DIV - 1);
      rdy_e = (t_e && m_mode != M_IDLE) ? mask : 4'b0000;
      chk("tick", tick, t_e);
      chk("ready", ch_if.ch_ready, rdy_e);
      chk("pwm", pwm, m_pwm);
      chk("underrun", under, m_under);
      chk("active", active, (m_mode != M_IDLE));
    end
    if (rst) model_reset();
    else model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("wait_tick", tick, 1);
  endtask

  task automatic wait_level(input int lvl);
    int n = 0;
    while (m_level != lvl && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst             = 1'b1;
    enable          = 1'b0;
    mask            = 4'hF;
    clr             = 1'b0;
    ch_if.ch_valid  = 4'hF;
    ch_if.ch_data   = 16'hFFFF;
    model_reset();
    step();
    checking = 1'b1;
    step();
    chk("rst_pwm", pwm, 0);
    chk("rst_active", active, 0);

    // 1: ramp up to RUN with all channels at 15
    rst = 1'b0;
    step();                      // cycle 0
    enable = 1'b1;
    repeat (4) step();           // cycles 1..4
    chk("t1_pwm", pwm, 8);
    for (int k = 2; k <= 8; k++) begin
      repeat (4) step();
      chk("t1_pwm", pwm, (k == 8) ? 60 : 8 * k);
    end
    chk("t1_active", active, 1);
    chk("t1_under", under, 0);

    // 2: ramp down to IDLE
    enable = 1'b0;
    repeat (4) step();
    chk("t2_pwm", pwm, 55);
    for (int k = 2; k <= 8; k++) begin
      repeat (4) step();
      chk("t2_pwm", pwm, (63 - 8 * k < 0) ? 0 : 63 - 8 * k);
    end
    chk("t2_active", active, 0);
    wait_tick();
    chk("t2_ready_idle", ch_if.ch_ready, 0);
    step();

    // 3: underrun on channel 2, clear-vs-set priority
    enable = 1'b1;
    repeat (40) step();
    chk("t3_run_pwm", pwm, 60);
    wait_tick();
    ch_if.ch_valid = 4'b1011;
    ch_if.ch_data  = 16'h5555;
    step();
    chk("t3_under_set", under, 4'b0100);
    step();
    chk("t3_pwm_hold", pwm, 30);
    wait_tick();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_set_wins", under, 4'b0100);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_cleared", under, 0);

    // 4: two-channel mix
    ch_if.ch_valid = 4'hF;
    mask           = 4'b0011;
    ch_if.ch_data  = 16'h77AF;
    wait_tick();
    chk("t4_ready", ch_if.ch_ready, 4'b0011);
    step();
    step();
    chk("t4_pwm", pwm, 25);

    // 5: brief disable during ramp-up
    enable = 1'b0;
    repeat (40) step();
    chk("t5_idle", active, 0);
    mask          = 4'hF;
    ch_if.ch_data = 16'hFFFF;
    enable        = 1'b1;
    wait_level(24);
    step();
    chk("t5_pwm24", pwm, 24);
    enable = 1'b0;
    wait_level(16);
    step();
    chk("t5_pwm16", pwm, 16);
    enable = 1'b1;
    wait_level(24);
    step();
    chk("t5_pwm24b", pwm, 24);
    wait_level(32);
    step();
    chk("t5_pwm32", pwm, 32);

    // 6: reset from RUN
    repeat (40) step();
    chk("t6_run", pwm, 60);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_pwm", pwm, 0);
    chk("t6_active", active, 0);
    for (int c = 0; c < 4; c++) begin
      chk("t6_tick", tick, (c == 3));
      step();
    end

    // randomized phase
    for (int n = 0; n < 600; n++) begin
      ch_if.ch_data  = 16'($urandom);
      ch_if.ch_valid = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 49) == 0) mask = 4'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_mix_sched.md
Name: audio_mix_sched

Overview:
- Sample scheduler and mixer that feeds the `data` input of the audio PWM delta-modulator.
- A prescaler generates the audio sample rate. Four channel sources are polled with a valid/ready handshake once per sample period, and the accepted samples are summed.
- A ramp state machine fades the output ceiling up and down, so enabling or disabling audio causes no pop.
- Output `pwm_data` connects directly to the PWM block's `data` port.

Parameters:
- WIDTH, 6, PWM data width; each channel sample is WIDTH-2 bits.
- DIV, 64, clocks per sample period (≥2).
- STEP, 1, ramp ceiling increment/decrement per sample tick (1..2^WIDTH-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  audio enable; sampled every clock.
- ch_mask  in  4  per-channel enable; masked channel contributes 0 and is not handshaked.
- ch_data  in  4*(WIDTH-2)  channel samples, unsigned; channel i at bits [i*(WIDTH-2) +: WIDTH-2].
- ch_valid  in  4  channel i has a sample available.
- ch_ready  out  4  one-cycle pulse: sample accepted when ch_valid[i] & ch_ready[i].
- clr_underrun  in  1  clears the underrun flags.
- pwm_data  out  WIDTH  mixed, ramp-limited sample to the PWM.
- sample_tick  out  1  one-cycle pulse, once per DIV clocks.
- underrun  out  4  sticky flags: a tick found an enabled channel not valid.
- active  out  1  high when state != IDLE.

Behaviour:

Reset (rst=1 at a clock edge):
- cnt=0, state=IDLE, level=0, all sample registers=0, pwm_data=0, sample_tick=0, ch_ready=0, underrun=0, active=0.
- Reset mid-ramp or mid-run drops to IDLE immediately; there is no ramp-down.

Prescaler:
- cnt counts 0..DIV-1 and wraps; it runs in every state.
- sample_tick=1 exactly when cnt==DIV-1 (combinational from cnt). The first tick is the DIV-th cycle after reset release.

States: IDLE, RAMP_UP, RUN, RAMP_DOWN.
- IDLE & enable → RAMP_UP on the next edge, without waiting for a tick.
- RAMP_UP:
  - On each tick, level ← min(level+STEP, 2^WIDTH-1).
  - If the new level equals 2^WIDTH-1 → RUN on the same edge.
  - If !enable (checked every clock) → RAMP_DOWN from the current level.
- RUN & !enable → RAMP_DOWN.
- RAMP_DOWN:
  - On each tick, level ← max(level-STEP, 0).
  - If the new level is 0 → IDLE on the same edge.
  - If enable is reasserted → RAMP_UP from the current level.
- If a tick and a state change occur in the same cycle, the level update uses the current state's rule.

Handshake:
- ch_ready[i] = sample_tick & ch_mask[i] & (state != IDLE).
- On an accept, sample_i ← ch_data slice at that edge.
- An enabled channel that is not valid at a tick keeps its previous sample and sets underrun[i].
- A masked channel's sample register is forced to 0 at each tick.
- clr_underrun clears all flags. If a set and a clear occur in the same cycle, set wins.

Mix and latency:
- sum = sample_0+sample_1+sample_2+sample_3, computed at WIDTH bits. The maximum is 2^WIDTH-4, so there is no overflow.
- Every cycle, pwm_data is registered as: 0 if state==IDLE, else min(sum, level).
- Latency: a sample accepted at tick cycle T appears in pwm_data in cycle T+2. A level update at T is also reflected at T+2.
- The IDLE→RAMP_UP transition itself does not change pwm_data until level rises.

Test Plan:
Bench settings: WIDTH=6, DIV=4, STEP=8, ch_mask=4'hF. Reset is released at cycle 0, so ticks fall at cycles 3, 7, 11, ….

1. All channels valid with data 15, enable=1 from cycle 1 → ch_ready=4'hF at each tick. pwm_data after successive ticks = 8, 16, 24, 32, 40, 48, 56, then 60 (level saturates at 63 on the 8th tick; state=RUN). underrun stays 0.
2. From RUN, enable=0 → level steps 55, 47, …, 7, then 0. pwm_data = min(60, level) at each step. state=IDLE and active=0 after the tick that reaches 0, and ch_ready stays 0 afterwards.
3. In RUN, ch_valid[2]=0 at a tick → sample_2 is held, underrun=4'b0100. Assert clr_underrun in the same cycle as another tick with channel 2 still invalid → flag stays set. Clear it on a non-tick cycle → 0.
4. ch_mask=4'b0011 with channel data 15 and 10 → sum=25. ch_ready[3:2] is never asserted, and pwm_data reaches 25 in RUN.
5. In RAMP_UP at level 24, deassert enable for one tick then reassert → level goes 24→16→24→32…. pwm_data tracks min(sum, level) with 2-cycle latency.
6. Assert rst in RUN → next cycle pwm_data=0, active=0, cnt=0, and the next tick occurs 4 cycles after reset release.
